// File: rtl/oldland_dbus_bridge.sv
`default_nettype none
//============================================================================
// Module      : oldland_dbus_bridge
// Description : Bridges the Oldland CPU memory-stage data port onto an
//               external request/acknowledge bus. A request seen in IDLE is
//               registered onto the bus and held there until the bus answers.
//               The answer is returned as a single-cycle d_ack or d_error
//               pulse, and any read data is latched onto d_data.
//
// Ports       : clk, rst            - clock, synchronous active-high reset
//               d_addr/d_bytesel/d_wr_en/d_wr_val/d_access
//                                   - request from the memory stage
//               d_data/d_ack/d_error
//                                   - response to the memory stage
//               bus_addr/bus_bytesel/bus_wr_en/bus_wr_val/bus_access
//                                   - registered request on the external bus
//               bus_data/bus_ack/bus_error
//                                   - response from the external bus
//
// Parameters  : timeout_cycles - BUS cycles without a response before the
//                                transaction is failed (1..65535)
// Macros      : OLDLAND_DBUS_TIMEOUT_EN - when defined, enables the timeout
//                                counter; otherwise BUS waits indefinitely.
//
// Revision    : 1.0 - initial release
//============================================================================
module oldland_dbus_bridge #(
    parameter int unsigned timeout_cycles = 256
) (
    input  logic        clk,
    input  logic        rst,
    // Memory-stage side
    input  logic [29:0] d_addr,
    input  logic [3:0]  d_bytesel,
    input  logic        d_wr_en,
    input  logic [31:0] d_wr_val,
    input  logic        d_access,
    output logic [31:0] d_data,
    output logic        d_ack,
    output logic        d_error,
    // External bus side
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_bytesel,
    output logic        bus_wr_en,
    output logic [31:0] bus_wr_val,
    output logic        bus_access,
    input  logic [31:0] bus_data,
    input  logic        bus_ack,
    input  logic        bus_error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [29:0] r_addr;
    logic [3:0]  r_bytesel;
    logic        r_wr_en;
    logic [31:0] r_wr_val;
    logic [31:0] r_data;
    logic        r_ack;
    logic        r_err;

    logic        w_capture;
    logic        w_ack_next;
    logic        w_err_next;
    logic [31:0] w_data_next;
    logic        w_timeout;

`ifdef OLDLAND_DBUS_TIMEOUT_EN
    // The counter holds the number of completed BUS cycles without a
    // response, so the last permitted cycle is the one where it reads
    // timeout_cycles-1.
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(timeout_cycles - 1);

    logic [15:0] r_count;

    assign w_timeout = (r_count == c_TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 16'd0;
        end else if (w_capture) begin
            r_count <= 16'd0;
        end else if (r_state == ST_BUS && !bus_ack && !bus_error) begin
            r_count <= r_count + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and response decode. bus_error is tested before bus_ack so
    // an erroring bus can never be reported as a successful completion, and
    // any real response beats a timeout falling in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_ack_next   = 1'b0;
        w_err_next   = 1'b0;
        w_data_next  = r_data;
        case (r_state)
            ST_IDLE: begin
                if (d_access) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                if (bus_error) begin
                    w_state_next = ST_RESP;
                    w_err_next   = 1'b1;
                    w_data_next  = 32'd0;
                end else if (bus_ack) begin
                    w_state_next = ST_RESP;
                    w_ack_next   = 1'b1;
                    if (!r_wr_en) begin
                        w_data_next = bus_data;
                    end
                end else if (w_timeout) begin
                    w_state_next = ST_RESP;
                    w_err_next   = 1'b1;
                    w_data_next  = 32'd0;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= 30'd0;
            r_bytesel <= 4'd0;
            r_wr_en   <= 1'b0;
            r_wr_val  <= 32'd0;
            r_data    <= 32'd0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_ack_next;
            r_err   <= w_err_next;
            r_data  <= w_data_next;
            if (w_capture) begin
                r_addr    <= d_addr;
                r_bytesel <= d_bytesel;
                r_wr_en   <= d_wr_en;
                r_wr_val  <= d_wr_val;
            end
        end
    end

    assign bus_addr    = r_addr;
    assign bus_bytesel = r_bytesel;
    assign bus_wr_en   = r_wr_en;
    assign bus_wr_val  = r_wr_val;
    assign bus_access  = (r_state == ST_BUS);

    assign d_data  = r_data;
    assign d_ack   = r_ack;
    assign d_error = r_err;

endmodule
`default_nettype wire
